// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 widths, FSM states, lane offset width.
package lsu_pkg;

  localparam int unsigned OFF_W = 2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } lsu_state_t;

  // Unsigned widths exist only for loads; anything else outside B/H/W is undefined.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    logic ill;
    case (f3)
      F3_B, F3_H, F3_W: ill = 1'b0;
      F3_BU, F3_HU:     ill = we;
      default:          ill = 1'b1;
    endcase
    return ill;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store masks/replication, load extraction and extension.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RAM_AMOUNT = 4
) (
  input  logic [2:0]            i_funct3,
  input  logic [OFF_W-1:0]      i_off,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_dout,
  output logic [RAM_AMOUNT-1:0] o_ctrl,
  output logic [DATA_WIDTH-1:0] o_di,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_misaligned
);

  localparam int unsigned SH_W = OFF_W + 3;

  logic [SH_W-1:0]       w_shamt;
  logic [DATA_WIDTH-1:0] w_lane;

  assign w_shamt = {i_off, 3'b000};
  assign w_lane  = i_mem_dout >> w_shamt;

  always_comb begin
    o_ctrl       = '0;
    o_di         = '0;
    o_rdata      = '0;
    o_misaligned = 1'b0;
    case (i_funct3)
      F3_B, F3_BU: begin
        o_ctrl  = RAM_AMOUNT'(1) << i_off;
        o_di    = {(DATA_WIDTH/8){i_wdata[7:0]}};
        o_rdata = (i_funct3 == F3_B) ? {{(DATA_WIDTH-8){w_lane[7]}}, w_lane[7:0]}
                                     : {{(DATA_WIDTH-8){1'b0}}, w_lane[7:0]};
      end
      F3_H, F3_HU: begin
        o_ctrl       = RAM_AMOUNT'(2'b11) << {i_off[1], 1'b0};
        o_di         = {(DATA_WIDTH/16){i_wdata[15:0]}};
        o_rdata      = (i_funct3 == F3_H) ? {{(DATA_WIDTH-16){w_lane[15]}}, w_lane[15:0]}
                                          : {{(DATA_WIDTH-16){1'b0}}, w_lane[15:0]};
        o_misaligned = i_off[0];
      end
      F3_W: begin
        o_ctrl       = '1;
        o_di         = i_wdata;
        o_rdata      = w_lane;
        o_misaligned = (i_off != '0);
      end
      default: begin
        o_ctrl       = '0;
        o_di         = '0;
        o_rdata      = '0;
        o_misaligned = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator for the 4-bank byte-enabled data memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RAM_AMOUNT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_we,
  output logic                  mem_rd,
  output logic [RAM_AMOUNT-1:0] mem_ctrl,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_di,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  input  logic                  mem_dout_ready
);

  lsu_state_t r_state, w_state_nxt;

  logic                  r_we;
  logic [2:0]            r_funct3;
  logic [OFF_W-1:0]      r_off;

  logic                  r_req_ready, r_resp_valid, r_resp_err, r_mem_we, r_mem_rd;
  logic [DATA_WIDTH-1:0] r_resp_rdata, r_mem_addr, r_mem_di;
  logic [RAM_AMOUNT-1:0] r_mem_ctrl;

  logic                  w_req_ready_nxt, w_resp_valid_nxt, w_resp_err_nxt;
  logic                  w_mem_we_nxt, w_mem_rd_nxt;
  logic [DATA_WIDTH-1:0] w_resp_rdata_nxt, w_mem_addr_nxt, w_mem_di_nxt;
  logic [RAM_AMOUNT-1:0] w_mem_ctrl_nxt;

  logic [2:0]            w_funct3;
  logic [OFF_W-1:0]      w_off;
  logic [RAM_AMOUNT-1:0] w_ctrl;
  logic [DATA_WIDTH-1:0] w_di, w_ld_data;
  logic                  w_misaligned, w_req_err;

  // Shared aligner sees the incoming request in IDLE and the latched load afterwards.
  assign w_funct3 = (r_state == IDLE) ? req_funct3 : r_funct3;
  assign w_off    = (r_state == IDLE) ? req_addr[OFF_W-1:0] : r_off;

  lsu_lane_align #(
    .DATA_WIDTH (DATA_WIDTH),
    .RAM_AMOUNT (RAM_AMOUNT)
  ) u_align (
    .i_funct3     (w_funct3),
    .i_off        (w_off),
    .i_wdata      (req_wdata),
    .i_mem_dout   (mem_dout),
    .o_ctrl       (w_ctrl),
    .o_di         (w_di),
    .o_rdata      (w_ld_data),
    .o_misaligned (w_misaligned)
  );

  assign w_req_err = f3_illegal(req_we, req_funct3) | w_misaligned;

  always_comb begin
    w_state_nxt      = r_state;
    w_mem_we_nxt     = 1'b0;
    w_mem_rd_nxt     = 1'b0;
    w_mem_ctrl_nxt   = '0;
    w_mem_addr_nxt   = '0;
    w_mem_di_nxt     = '0;
    w_resp_err_nxt   = 1'b0;
    w_resp_rdata_nxt = '0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (w_req_err) begin
            w_state_nxt    = RESP;
            w_resp_err_nxt = 1'b1;
          end else begin
            w_state_nxt    = ACCESS;
            w_mem_we_nxt   = req_we;
            w_mem_rd_nxt   = !req_we;
            w_mem_ctrl_nxt = req_we ? w_ctrl : '1;
            w_mem_addr_nxt = {OFF_W'(0), req_addr[DATA_WIDTH-1:OFF_W]};
            w_mem_di_nxt   = req_we ? w_di : '0;
          end
        end
      end
      ACCESS: w_state_nxt = r_we ? RESP : WAIT;
      WAIT: begin
        if (mem_dout_ready) begin
          w_state_nxt      = RESP;
          w_resp_rdata_nxt = w_ld_data;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_resp_valid_nxt = (w_state_nxt == RESP);
  assign w_req_ready_nxt  = (w_state_nxt == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_mem_we     <= 1'b0;
      r_mem_rd     <= 1'b0;
      r_mem_ctrl   <= '0;
      r_mem_addr   <= '0;
      r_mem_di     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_req_ready  <= w_req_ready_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_err   <= w_resp_err_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_rd     <= w_mem_rd_nxt;
      r_mem_ctrl   <= w_mem_ctrl_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_di     <= w_mem_di_nxt;
    end
  end

  // Request fields needed after acceptance for load extraction and next-state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we     <= 1'b0;
      r_funct3 <= '0;
      r_off    <= '0;
    end else if (r_state == IDLE && req_valid) begin
      r_we     <= req_we;
      r_funct3 <= req_funct3;
      r_off    <= req_addr[OFF_W-1:0];
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;
  assign mem_we     = r_mem_we;
  assign mem_rd     = r_mem_rd;
  assign mem_ctrl   = r_mem_ctrl;
  assign mem_addr   = r_mem_addr;
  assign mem_di     = r_mem_di;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: vector table through a memory harness, scoreboarded responses.
module tb_load_store_unit;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [3:0]  exp_ctrl;
    logic [31:0] exp_di;
  } vec_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  localparam int NV = 17;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_we, mem_rd;
  logic [3:0]  mem_ctrl;
  logic [31:0] mem_addr, mem_di, mem_dout;
  logic        mem_dout_ready;

  int total = 0;
  int bad   = 0;
  exp_t sb_q[$];
  vec_t vecs[NV];

  int          stall_cfg = 0;
  int          stall_left = 0;
  bit          pend = 0;
  bit          mem_init = 0;
  logic [7:0]  raddr = '0;
  logic [31:0] hmem[256];

  load_store_unit #(.DATA_WIDTH(32), .RAM_AMOUNT(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_we         (mem_we),
    .mem_rd         (mem_rd),
    .mem_ctrl       (mem_ctrl),
    .mem_addr       (mem_addr),
    .mem_di         (mem_di),
    .mem_dout       (mem_dout),
    .mem_dout_ready (mem_dout_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Memory harness: data appears the cycle after the read, optionally stalled.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (!mem_init) begin
        for (int i = 0; i < 256; i++) hmem[i] = '0;
        mem_init = 1'b1;
      end
      pend           = 1'b0;
      mem_dout_ready = 1'b0;
      mem_dout       = '0;
    end else begin
      mem_dout_ready = 1'b0;
      if (pend) begin
        if (stall_left == 0) begin
          mem_dout       = hmem[raddr];
          mem_dout_ready = 1'b1;
          pend           = 1'b0;
        end else begin
          stall_left--;
        end
      end
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_ctrl[b]) hmem[mem_addr[7:0]][8*b +: 8] = mem_di[8*b +: 8];
      end
      if (mem_rd) begin
        pend       = 1'b1;
        stall_left = stall_cfg;
        raddr      = mem_addr[7:0];
      end
    end
  end

  // Response scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && resp_valid) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp actual=1 required=0 t=%0t", $time);
      end else begin
        e = sb_q.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_err", 32'(resp_err), 32'(e.err));
      end
    end
  end

  task automatic do_req(input vec_t v, input int stall, input string nm);
    int cyc;
    int lat_exp;
    int guard;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({nm, " ready_idle"}, 32'(req_ready), 32'd1);
    stall_cfg  = stall;
    req_valid  = 1'b1;
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    sb_q.push_back('{rdata: v.exp_rdata, err: v.exp_err});
    @(posedge clk);
    @(negedge clk);
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = '0;
    req_addr   = '0;
    req_wdata  = '0;
    lat_exp = v.exp_err ? 1 : (v.we ? 2 : 3 + stall);
    cyc = 1;
    while (cyc < 40) begin
      if (cyc == 1 && !v.exp_err) begin
        check({nm, " mem_we"},   32'(mem_we), 32'(v.we));
        check({nm, " mem_rd"},   32'(mem_rd), 32'(!v.we));
        check({nm, " mem_ctrl"}, 32'(mem_ctrl), 32'(v.exp_ctrl));
        check({nm, " mem_addr"}, mem_addr, v.addr >> 2);
        check({nm, " mem_di"},   mem_di, v.exp_di);
      end else begin
        check({nm, " mem_idle"}, 32'(|{mem_we, mem_rd, mem_ctrl, mem_addr, mem_di}), 32'd0);
      end
      check({nm, " ready_busy"}, 32'(req_ready), 32'd0);
      if (resp_valid) break;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    check({nm, " latency"}, 32'(cyc), 32'(lat_exp));
    @(posedge clk);
    @(negedge clk);
    check({nm, " resp_pulse"}, 32'(resp_valid), 32'd0);
    check({nm, " ready_back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = '0;
    req_addr   = '0;
    req_wdata  = '0;

    vecs[0]  = '{1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        1'b0, 4'hF, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 3'b000, 32'h103, 32'h0,        32'hFFFFFFDE, 1'b0, 4'hF, 32'h0};
    vecs[2]  = '{1'b0, 3'b100, 32'h103, 32'h0,        32'h000000DE, 1'b0, 4'hF, 32'h0};
    vecs[3]  = '{1'b0, 3'b001, 32'h100, 32'h0,        32'hFFFFBEEF, 1'b0, 4'hF, 32'h0};
    vecs[4]  = '{1'b0, 3'b101, 32'h102, 32'h0,        32'h0000DEAD, 1'b0, 4'hF, 32'h0};
    vecs[5]  = '{1'b1, 3'b001, 32'h102, 32'h00001234, 32'h0,        1'b0, 4'hC, 32'h12341234};
    vecs[6]  = '{1'b0, 3'b010, 32'h100, 32'h0,        32'h1234BEEF, 1'b0, 4'hF, 32'h0};
    vecs[7]  = '{1'b1, 3'b000, 32'h105, 32'h000000A5, 32'h0,        1'b0, 4'h2, 32'hA5A5A5A5};
    vecs[8]  = '{1'b0, 3'b000, 32'h105, 32'h0,        32'hFFFFFFA5, 1'b0, 4'hF, 32'h0};
    vecs[9]  = '{1'b0, 3'b101, 32'h104, 32'h0,        32'h0000A500, 1'b0, 4'hF, 32'h0};
    vecs[10] = '{1'b0, 3'b001, 32'h106, 32'h0,        32'h00000000, 1'b0, 4'hF, 32'h0};
    vecs[11] = '{1'b0, 3'b010, 32'h101, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0};
    vecs[12] = '{1'b0, 3'b001, 32'h103, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0};
    vecs[13] = '{1'b1, 3'b100, 32'h100, 32'h000000FF, 32'h0,        1'b1, 4'h0, 32'h0};
    vecs[14] = '{1'b0, 3'b011, 32'h100, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0};
    vecs[15] = '{1'b0, 3'b100, 32'h101, 32'h0,        32'h000000BE, 1'b0, 4'hF, 32'h0};
    vecs[16] = '{1'b0, 3'b000, 32'h100, 32'h0,        32'hFFFFFFEF, 1'b0, 4'hF, 32'h0};

    #12;
    check("rst req_ready",  32'(req_ready), 32'd1);
    check("rst resp_valid", 32'(resp_valid), 32'd0);
    check("rst resp_err",   32'(resp_err), 32'd0);
    check("rst resp_rdata", resp_rdata, 32'd0);
    check("rst mem_out",    32'(|{mem_we, mem_rd, mem_ctrl, mem_addr, mem_di}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) do_req(vecs[i], 0, $sformatf("v%0d", i));

    do_req('{1'b0, 3'b010, 32'h100, 32'h0, 32'h1234BEEF, 1'b0, 4'hF, 32'h0}, 3, "stall3");

    // Reset while a load sits in WAIT: aborts with no response.
    stall_cfg  = 10;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h100;
    @(posedge clk);
    @(negedge clk);
    req_valid  = 1'b0;
    check("abort access_rd", 32'(mem_rd), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("abort in_wait", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("abort req_ready",  32'(req_ready), 32'd1);
    check("abort resp_valid", 32'(resp_valid), 32'd0);
    check("abort mem_out",    32'(|{mem_we, mem_rd, mem_ctrl, mem_addr, mem_di}), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    stall_cfg = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("abort no_resp", 32'(resp_valid), 32'd0);
    end

    do_req('{1'b0, 3'b001, 32'h102, 32'h0, 32'h00001234, 1'b0, 4'hF, 32'h0}, 0, "post_rst");

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
